rgb_status_ctrl: RTL



---
 rtl/rgb_status_pkg.sv | 55 +++++
 rtl/rgb_status_ctrl_pwm_channel.sv | 18 +
 rtl/rgb_status_ctrl.sv | 163 ++++++++++++++++
 3 files changed

// File: rtl/rgb_status_pkg.sv
// rgb_status_pkg: shared types, command codes and the
// command -> {channel mask, lighting mode} table.
package rgb_status_pkg;

  typedef enum logic [1:0] {
    MODE_SOLID   = 2'd0,
    MODE_BREATHE = 2'd1,
    MODE_BLINK   = 2'd2
  } mode_t;

  typedef enum logic [2:0] {
    ST_SOLID     = 3'd0,
    ST_RAMP_UP   = 3'd1,
    ST_RAMP_DN   = 3'd2,
    ST_BLINK_ON  = 3'd3,
    ST_BLINK_OFF = 3'd4
  } state_t;

  localparam logic [7:0] CMD_OK           = 8'd0;
  localparam logic [7:0] CMD_RED_BREATHE  = 8'd1;
  localparam logic [7:0] CMD_BLUE_BREATHE = 8'd2;
  localparam logic [7:0] CMD_ALERT_BLINK  = 8'd3;
  localparam logic [7:0] CMD_ALL_SOLID    = 8'd4;

  // rgb covers ch0..ch2; all lights every channel,
  // so channels above ch2 are lit only by it.
  typedef struct packed {
    logic       all;
    logic [2:0] rgb;
    mode_t      mode;
  } cmd_ent_t;

  function automatic cmd_ent_t cmd_lookup(
    input logic [7:0] code
  );
    cmd_ent_t e;
    e = '{all: 1'b0, rgb: 3'b001, mode: MODE_BREATHE};
    unique case (code)
      CMD_OK:
        e = '{all: 1'b0, rgb: 3'b010, mode: MODE_SOLID};
      CMD_RED_BREATHE:
        e = '{all: 1'b0, rgb: 3'b001, mode: MODE_BREATHE};
      CMD_BLUE_BREATHE:
        e = '{all: 1'b0, rgb: 3'b100, mode: MODE_BREATHE};
      CMD_ALERT_BLINK:
        e = '{all: 1'b0, rgb: 3'b011, mode: MODE_BLINK};
      CMD_ALL_SOLID:
        e = '{all: 1'b1, rgb: 3'b111, mode: MODE_SOLID};
      default:
        e = '{all: 1'b0, rgb: 3'b001, mode: MODE_BREATHE};
    endcase
    return e;
  endfunction

endpackage

// File: rtl/rgb_status_ctrl_pwm_channel.sv
// pwm_channel: one registered PWM comparator against the
// shared free-running counter.
module pwm_channel #(
  parameter int PW = 8
) (
  input  logic          clk,
  input  logic          rst,
  input  logic [PW-1:0] pcnt,
  input  logic [PW-1:0] level_in,
  output logic          pwm
);

  always_ff @(posedge clk) begin
    if (rst) pwm <= 1'b0;
    else     pwm <= (pcnt < level_in);
  end

endmodule

// File: rtl/rgb_status_ctrl.sv
// rgb_status_ctrl: command-driven RGB status light with
// solid / breathe / blink envelope and per-channel PWM.
module rgb_status_ctrl
  import rgb_status_pkg::*;
#(
  parameter int NCH        = 3,
  parameter int PW         = 8,
  parameter int RAMP_DIV   = 50000,
  parameter int BLINK_HALF = 12500000
) (
  input  logic              FPGA_CLK1_50,
  input  logic              rst,
  input  logic [7:0]        cmd,
  output logic [NCH*PW-1:0] level,
  output logic [NCH-1:0]    pwm_out,
  output logic [2:0]        mode_o
);

  localparam logic [PW-1:0] LMAX = '1;
  localparam int MAXDIV =
    (RAMP_DIV > BLINK_HALF) ? RAMP_DIV : BLINK_HALF;
  localparam int CW =
    (MAXDIV > 1) ? $clog2(MAXDIV) : 1;
  localparam logic [CW-1:0] RAMP_END  = CW'(RAMP_DIV - 1);
  localparam logic [CW-1:0] BLINK_END = CW'(BLINK_HALF - 1);

  logic [7:0]        cmd_q;
  logic              chg_q;
  logic [NCH-1:0]    mask_q;
  logic [NCH-1:0]    mask_n;
  state_t            state, state_n;
  logic [PW-1:0]     env, env_n;
  logic [CW-1:0]     pc, pc_n;
  logic [PW-1:0]     pcnt;
  logic [NCH*PW-1:0] level_q;
  cmd_ent_t          ent;

  assign ent = cmd_lookup(cmd_q);

  for (genvar c = 0; c < NCH; c++) begin : g_mask
    if (c < 3) begin : g_rgb
      assign mask_n[c] = ent.rgb[c] | ent.all;
    end else begin : g_ext
      assign mask_n[c] = ent.all;
    end
  end

  // A pending change outranks any prescale expiry.
  always_comb begin
    state_n = state;
    env_n   = env;
    pc_n    = pc;
    if (chg_q) begin
      pc_n = '0;
      unique case (ent.mode)
        MODE_SOLID: begin
          state_n = ST_SOLID;
          env_n   = LMAX;
        end
        MODE_BREATHE: begin
          state_n = ST_RAMP_UP;
          env_n   = '0;
        end
        MODE_BLINK: begin
          state_n = ST_BLINK_ON;
          env_n   = LMAX;
        end
        default: begin
          state_n = ST_SOLID;
          env_n   = LMAX;
        end
      endcase
    end else begin
      unique case (state)
        ST_SOLID: begin
          env_n = LMAX;
          pc_n  = '0;
        end
        ST_RAMP_UP: begin
          if (pc == RAMP_END) begin
            pc_n  = '0;
            env_n = env + 1'b1;
            if (env == LMAX - 1'b1) state_n = ST_RAMP_DN;
          end else begin
            pc_n = pc + 1'b1;
          end
        end
        ST_RAMP_DN: begin
          if (pc == RAMP_END) begin
            pc_n  = '0;
            env_n = env - 1'b1;
            if (env == PW'(1)) state_n = ST_RAMP_UP;
          end else begin
            pc_n = pc + 1'b1;
          end
        end
        ST_BLINK_ON: begin
          if (pc == BLINK_END) begin
            pc_n    = '0;
            env_n   = '0;
            state_n = ST_BLINK_OFF;
          end else begin
            pc_n = pc + 1'b1;
          end
        end
        ST_BLINK_OFF: begin
          if (pc == BLINK_END) begin
            pc_n    = '0;
            env_n   = LMAX;
            state_n = ST_BLINK_ON;
          end else begin
            pc_n = pc + 1'b1;
          end
        end
        default: begin
          state_n = ST_SOLID;
          env_n   = LMAX;
          pc_n    = '0;
        end
      endcase
    end
  end

  always_ff @(posedge FPGA_CLK1_50) begin
    if (rst) begin
      cmd_q   <= '0;
      chg_q   <= 1'b0;
      mask_q  <= '0;
      state   <= ST_SOLID;
      env     <= LMAX;
      pc      <= '0;
      pcnt    <= '0;
      level_q <= '0;
    end else begin
      cmd_q  <= cmd;
      chg_q  <= (cmd != cmd_q);
      mask_q <= mask_n;
      state  <= state_n;
      env    <= env_n;
      pc     <= pc_n;
      pcnt   <= pcnt + 1'b1;
      for (int c = 0; c < NCH; c++) begin
        level_q[c*PW +: PW] <= mask_q[c] ? env : '0;
      end
    end
  end

  for (genvar c = 0; c < NCH; c++) begin : g_pwm
    pwm_channel #(
      .PW(PW)
    ) u_pwm (
      .clk      (FPGA_CLK1_50),
      .rst      (rst),
      .pcnt     (pcnt),
      .level_in (level_q[c*PW +: PW]),
      .pwm      (pwm_out[c])
    );
  end

  assign level  = level_q;
  assign mode_o = state;

endmodule
